sbox_sequencer: RTL and testbench

SBOX_SEQUENCER -- requirements
Module: sbox_sequencer

---
 rtl/sbox_sequencer_if.sv | 37 +++
 rtl/sbox_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sbox_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sbox_sequencer_if.sv
// rtl/sbox_sequencer_if.sv - host control/status and generator-side signals of the S-box sequencer
interface sbox_sequencer_if;
  // host side
  logic        start;
  logic        abort;
  logic [31:0] key_x1;
  logic [31:0] key_x2;
  logic [31:0] key_x3;
  logic        busy;
  logic        done;
  logic        sbox_valid;
  logic        error;
  // chaos / S-box generator side
  logic [31:0] x1_initial;
  logic [31:0] x2_initial;
  logic [31:0] x3_initial;
  logic        chaos_reset;
  logic        gen_reset;
  logic        gen_enable_bar;
  logic        gen_ready;

  // sequencer view
  modport slave (
    input  start, abort, key_x1, key_x2, key_x3, gen_ready,
    output busy, done, sbox_valid, error,
    output x1_initial, x2_initial, x3_initial,
    output chaos_reset, gen_reset, gen_enable_bar
  );

  // environment view (host plus generators)
  modport master (
    output start, abort, key_x1, key_x2, key_x3, gen_ready,
    input  busy, done, sbox_valid, error,
    input  x1_initial, x2_initial, x3_initial,
    input  chaos_reset, gen_reset, gen_enable_bar
  );
endinterface

// File: rtl/sbox_sequencer.sv
// rtl/sbox_sequencer.sv - seeds, warms up and drives the chaos-based S-box generator
module sbox_sequencer #(
  parameter int unsigned WARMUP_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  sbox_sequencer_if.slave  bus
);

  // Counter must hold the largest per-state length, including the fixed 2-cycle SEED.
  localparam int unsigned MAX_A     = (WARMUP_CYCLES > TIMEOUT_CYCLES) ? WARMUP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_COUNT = (MAX_A > 2) ? MAX_A : 2;
  localparam int          CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] SEED_LAST    = CW'(2);
  localparam logic [CW-1:0] WARMUP_LAST  = CW'(WARMUP_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARMUP,
    S_GENERATE,
    S_HOLD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          timeout;

  logic          chaos_reset_q;
  logic          gen_reset_q;
  logic          gen_enable_bar_q;
  logic          busy_q;
  logic          done_q;
  logic          sbox_valid_q;
  logic          error_q;
  logic [31:0]   x1_q;
  logic [31:0]   x2_q;
  logic [31:0]   x3_q;

  logic          chaos_reset_next;
  logic          gen_reset_next;
  logic          gen_enable_bar_next;
  logic          busy_next;
  logic          done_next;
  logic          sbox_valid_next;
  logic          error_next;

  // State register and in-state cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= CNT_ONE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and next-output decode; abort overrides every other transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    timeout    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_SEED;
          accept     = 1'b1;
        end
      end
      S_SEED: begin
        if (cnt == SEED_LAST) state_next = S_WARMUP;
      end
      S_WARMUP: begin
        if (cnt == WARMUP_LAST) state_next = S_GENERATE;
      end
      S_GENERATE: begin
        // ready on the final timeout cycle still counts as success
        if (bus.gen_ready) begin
          state_next = S_HOLD;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = S_IDLE;
          timeout    = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.start) begin
          state_next = S_SEED;
          accept     = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (bus.abort) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      timeout    = 1'b0;
    end

    // Counter restarts at 1 on every state entry and only advances in timed states,
    // so it never exceeds the longest state length and cannot wrap.
    if (state_next != state) begin
      cnt_next = CNT_ONE;
    end else if (state == S_SEED || state == S_WARMUP || state == S_GENERATE) begin
      cnt_next = cnt + CNT_ONE;
    end

    // Outputs are registered from the state being entered so they line up with it.
    chaos_reset_next    = (state_next == S_IDLE) || (state_next == S_SEED);
    gen_reset_next      = (state_next == S_IDLE) || (state_next == S_SEED);
    gen_enable_bar_next = (state_next != S_GENERATE);
    busy_next           = (state_next == S_SEED) || (state_next == S_WARMUP) ||
                          (state_next == S_GENERATE);
    sbox_valid_next     = (state_next == S_HOLD);
    done_next           = (state == S_GENERATE) && (state_next == S_HOLD);

    error_next = error_q;
    if (accept) begin
      error_next = 1'b0;
    end else if (timeout) begin
      error_next = 1'b1;
    end
  end

  // Registered status and generator control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chaos_reset_q    <= 1'b1;
      gen_reset_q      <= 1'b1;
      gen_enable_bar_q <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      sbox_valid_q     <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      chaos_reset_q    <= chaos_reset_next;
      gen_reset_q      <= gen_reset_next;
      gen_enable_bar_q <= gen_enable_bar_next;
      busy_q           <= busy_next;
      done_q           <= done_next;
      sbox_valid_q     <= sbox_valid_next;
      error_q          <= error_next;
    end
  end

  // Seed registers capture the keys only when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q <= 32'h0;
      x2_q <= 32'h0;
      x3_q <= 32'h0;
    end else if (accept) begin
      x1_q <= bus.key_x1;
      x2_q <= bus.key_x2;
      x3_q <= bus.key_x3;
    end
  end

  assign bus.chaos_reset    = chaos_reset_q;
  assign bus.gen_reset      = gen_reset_q;
  assign bus.gen_enable_bar = gen_enable_bar_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.sbox_valid     = sbox_valid_q;
  assign bus.error          = error_q;
  assign bus.x1_initial     = x1_q;
  assign bus.x2_initial     = x2_q;
  assign bus.x3_initial     = x3_q;

endmodule

// File: tb/tb_sbox_sequencer.sv
// tb/tb_sbox_sequencer.sv - self-checking bench for sbox_sequencer against a build-timeline model
module tb_sbox_sequencer;
  localparam int W = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sbox_sequencer_if bus();

  sbox_sequencer #(.WARMUP_CYCLES(W), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a build is a numbered run of cycles since acceptance.
  // Cycles 1..2 seed, 3..2+W warm up, 3+W..2+W+T generate.
  bit          m_build;
  bit          m_valid;
  bit          m_err;
  bit          m_done;
  int          m_since;
  logic [31:0] m_x1, m_x2, m_x3;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_build = 0; m_valid = 0; m_err = 0; m_done = 0; m_since = 0;
    m_x1 = 0; m_x2 = 0; m_x3 = 0;
  endtask

  function automatic bit in_gen();
    return m_build && (m_since > 2 + W);
  endfunction

  task automatic model_edge();
    m_done = 0;
    if (bus.abort) begin
      m_build = 0;
      m_valid = 0;
    end else if (!m_build && bus.start) begin
      m_build = 1; m_since = 1; m_valid = 0; m_err = 0;
      m_x1 = bus.key_x1; m_x2 = bus.key_x2; m_x3 = bus.key_x3;
    end else if (m_build) begin
      if (in_gen()) begin
        if (bus.gen_ready) begin
          m_build = 0; m_valid = 1; m_done = 1;
        end else if (m_since - 2 - W == T) begin
          m_build = 0; m_err = 1;
        end else begin
          m_since++;
        end
      end else begin
        m_since++;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_rst;
    exp_rst = m_build ? (m_since <= 2) : !m_valid;
    chk("chaos_reset", bus.chaos_reset, exp_rst);
    chk("gen_reset", bus.gen_reset, exp_rst);
    chk("gen_enable_bar", bus.gen_enable_bar, !in_gen());
    chk("busy", bus.busy, m_build);
    chk("done", bus.done, m_done);
    chk("sbox_valid", bus.sbox_valid, m_valid);
    chk("error", bus.error, m_err);
    chk("x1_initial", bus.x1_initial, m_x1);
    chk("x2_initial", bus.x2_initial, m_x2);
    chk("x3_initial", bus.x3_initial, m_x3);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    lat++;
    #1;
    check_outputs();
  endtask

  task automatic set_ready(input int ready_n);
    if (in_gen()) bus.gen_ready = (ready_n > 0) && (m_since - 2 - W >= ready_n);
    else bus.gen_ready = 1'($urandom_range(0, 1));
  endtask

  // ready_n: generate cycle on which gen_ready rises (0 = never);
  // abort_at: build cycle during which abort is held (0 = none);
  // noisy: toggle start and keys while busy.
  task automatic run_build(input logic [31:0] k1, input logic [31:0] k2, input logic [31:0] k3,
                           input int ready_n, input int abort_at, input bit noisy);
    bit finished;
    bus.key_x1 = k1; bus.key_x2 = k2; bus.key_x3 = k3;
    bus.start = 1; bus.abort = 0;
    bus.gen_ready = 1'($urandom_range(0, 1));
    lat = 0;
    step();
    bus.start = 0;
    finished = 0;
    for (int i = 0; i < 200 && !finished; i++) begin
      set_ready(ready_n);
      bus.abort = (abort_at != 0) && m_build && (m_since == abort_at);
      if (noisy) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.key_x1 = $urandom; bus.key_x2 = $urandom; bus.key_x3 = $urandom;
      end
      step();
      if (bus.done === 1'b1) chk("latency", lat, 2 + W + ready_n + 1);
      if (!m_build) finished = 1;
    end
    bus.start = 0; bus.abort = 0; bus.gen_ready = 0;
    chk("build_bound", finished, 1);
    bus.key_x1 = $urandom; bus.key_x2 = $urandom; bus.key_x3 = $urandom;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 0; bus.abort = 0; bus.gen_ready = 0;
    bus.key_x1 = 32'hDEADBEEF; bus.key_x2 = 32'h12345678; bus.key_x3 = 32'hCAFEF00D;
    reset = 1;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    reset = 0;
    step();

    // nominal build: 10 generate cycles, latency 17
    run_build(32'h3F800000, 32'h40000000, 32'h40400000, 10, 0, 0);
    chk("nominal_x1", bus.x1_initial, 32'h3F800000);
    chk("nominal_x2", bus.x2_initial, 32'h40000000);
    chk("nominal_x3", bus.x3_initial, 32'h40400000);
    chk("nominal_valid", bus.sbox_valid, 1);

    // timeout then next start clears error
    run_build($urandom, $urandom, $urandom, 0, 0, 0);
    chk("timeout_error", bus.error, 1);
    chk("timeout_valid", bus.sbox_valid, 0);
    run_build($urandom, $urandom, $urandom, 5, 0, 0);
    chk("error_cleared", bus.error, 0);

    // ready on the final timeout cycle wins
    run_build($urandom, $urandom, $urandom, T, 0, 0);
    chk("edge_ready_valid", bus.sbox_valid, 1);
    chk("edge_ready_error", bus.error, 0);

    // abort in warmup cycle 2
    run_build($urandom, $urandom, $urandom, 0, 2 + 2, 0);
    chk("abort_warmup_busy", bus.busy, 0);

    // abort together with start in HOLD
    run_build($urandom, $urandom, $urandom, 3, 0, 1);
    bus.key_x1 = $urandom; bus.key_x2 = $urandom; bus.key_x3 = $urandom;
    bus.abort = 1; bus.start = 1;
    step();
    bus.abort = 0; bus.start = 0;
    chk("abort_start_valid", bus.sbox_valid, 0);
    chk("abort_start_busy", bus.busy, 0);
    step();

    // reset mid-generate while start and keys churn
    bus.key_x1 = $urandom; bus.key_x2 = $urandom; bus.key_x3 = $urandom;
    bus.start = 1;
    step();
    for (int i = 0; i < 40 && m_since < 2 + W + 5; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.key_x1 = $urandom; bus.key_x2 = $urandom; bus.key_x3 = $urandom;
      bus.gen_ready = 0;
      step();
    end
    chk("pre_reset_gen", in_gen(), bus.gen_enable_bar == 1'b0);
    #2;
    reset = 1;
    #1;
    model_reset();
    check_outputs();
    bus.start = 0;
    step();
    reset = 0;
    step();

    // randomized builds
    for (int n = 0; n < 8; n++) begin
      int rn, ab;
      rn = $urandom_range(0, 20);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + W + 6) : 0;
      run_build($urandom, $urandom, $urandom, rn, ab, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
